// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable serial pattern detector.
//   Detects a pattern of 1..MAX_LEN bits on the qualified serial input x,
//   in overlapping or non-overlapping mode. The match pulse y is Mealy
//   (it rises in the same cycle as the last pattern bit).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   x, x_valid          serial bit and its qualifier
//   cfg_load            strobe that latches pattern / pat_len / overlap_en
//   pattern, pat_len    pattern[pat_len-1] is the first bit received
//   overlap_en          1 = overlapping, 0 = non-overlapping
//   count_clr           synchronous clear of match_count (wins over increment)
//   y                   match pulse
//   match_count         saturating match counter
//   cfg_err             last cfg_load carried an illegal pat_len
//   busy                detector is in RUN
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

  localparam logic [LEN_W:0]   MAX_C  = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  // The comparison window is MAX_LEN bits wide and always includes the
  // current x, so only MAX_LEN-1 past samples ever influence a match.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] cand, mask;
  logic [LEN_W:0]     fill_inc;
  logic               match, legal;

  assign cand     = {hist_q, x};
  // Only the low len bits take part in the compare.
  assign mask     = ~({MAX_LEN{1'b1}} << len_q);
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign match    = (fill_inc >= {1'b0, len_q}) && (((cand ^ pat_q) & mask) == '0);
  assign legal    = (pat_len != '0) && ({1'b0, pat_len} <= MAX_C);

  assign y           = (state_q == RUN) && x_valid && !cfg_load && match;
  assign busy        = (state_q == RUN);
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      // Reconfiguration from any state restarts detection from scratch.
      pat_d   = pattern;
      len_d   = pat_len;
      ovl_d   = overlap_en;
      hist_d  = '0;
      fill_d  = '0;
      state_d = legal ? RUN : ERR;
      err_d   = !legal;
    end else if (state_q == RUN && x_valid) begin
      hist_d = cand[MAX_LEN-2:0];
      if (match && !ovl_q)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_inc[LEN_W-1:0];
    end

    if (count_clr)
      cnt_d = '0;
    else if (y && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
